bullet_ctrl: RTL and testbench
==============================

Name: bullet_ctrl

Overview:
- Per-tank bullet engine; one instance per player.
- Latches a fire request and spawns a bullet at the tank centre in the tank's facing direction.
- Advances the bullet once per video frame.
- Produces the bullet position, launch-point and direction buses consumed by the wall/tank collision checker.
- Consumes that checker's wall-hit and opponent-alive verdicts to retire the bullet and count kills.

Parameters:
STEP_B, 5, pixels moved per frame (must equal the collision checker's bullet step)
BULLET_SIZE, 8, bullet edge length in pixels
TANK_SIZE, 32, tank edge length in pixels
SCREEN_W, 640, visible width; legal X range 0..SCREEN_W-1
SCREEN_H, 480, visible height; legal Y range 0..SCREEN_H-1
MAX_FRAMES, 120, maximum bullet lifetime in frames
COOLDOWN_FRAMES, 15, frames after retirement before the next fire is accepted

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
frame_clk  in  1  vertical-sync-rate frame clock; sampled on Clk, rising edge detected internally
fire  in  1  player fire key, level
X_Tank, Y_Tank  in  10 each  own tank top-left position
facing  in  3  own tank facing: 1 up, 2 right, 3 left, 4 down; other values invalid
hit  in  2  checker verdict for this bullet: 2'b00 wall hit, 2'b01 clear; other codes treated as clear
opp_alive  in  1  checker verdict; 0 = this bullet hit the opponent tank
X_Bullet, Y_Bullet  out  10 each  bullet top-left position
saveX, saveY  out  10 each  tank position latched at launch
bullet_dir  out  3  current bullet direction, same encoding as facing; 0 when no bullet
bullet_active  out  1  bullet in flight
kill_pulse  out  1  one-Clk pulse per opponent kill
kills  out  4  saturating kill count

Behaviour:
- Reset (Reset_n=0 at a Clk edge):
  - All outputs go to 0.
  - FSM goes to IDLE; frame/cooldown counters clear; fire and frame_clk edge registers clear.
  - Applies mid-flight: the bullet vanishes immediately; kills clears.
- frame_tick = frame_clk registered twice; rising edge (prev 0, now 1) gives a one-Clk tick.
- fire_edge = rising edge of registered fire. A held key fires only once; it must be released and re-pressed.
- FSM states:
  - IDLE:
    - On fire_edge with facing in 1..4: X_Bullet=X_Tank+12, Y_Bullet=Y_Tank+12, saveX/saveY=X_Tank/Y_Tank, bullet_dir=facing, bullet_active=1, life counter=0, go to FLIGHT.
    - Launch is visible the Clk cycle after fire_edge.
    - fire_edge with invalid facing is ignored.
  - FLIGHT: evaluated only on frame_tick, in this priority order:
    1. opp_alive==0: retire; kill_pulse=1 for exactly one Clk; kills+=1, saturating at 15.
    2. hit==2'b00: retire, no kill.
    3. Next position would leave the screen: retire. Bounds per direction:
       - up: Y_Bullet < STEP_B
       - left: X_Bullet < STEP_B
       - right: X_Bullet+BULLET_SIZE+STEP_B > SCREEN_W-1
       - down: Y_Bullet+BULLET_SIZE+STEP_B > SCREEN_H-1
       - Compute bounds at 11 bits; a 10-bit wrap must never occur.
    4. Life counter == MAX_FRAMES-1: retire.
    5. Otherwise: move STEP_B pixels in bullet_dir, life counter += 1.
  - Retire: bullet_active=0, bullet_dir=0. X_Bullet/Y_Bullet/saveX/saveY hold their last values. Go to COOLDOWN with counter=0.
  - COOLDOWN:
    - Counter increments on each frame_tick.
    - After COOLDOWN_FRAMES ticks, go to IDLE.
    - fire_edge during COOLDOWN is dropped, not queued.
- Between frame_ticks, FLIGHT ignores hit and opp_alive; the checker output is combinational and settles between frames.
- fire and facing are ignored outside IDLE; direction is fixed for the bullet's life.
- Simultaneous fire_edge and frame_tick in IDLE: launch wins; the bullet makes its first move on the next frame_tick.
- Simultaneous opp_alive==0 and hit==00: counts as a kill.

Test Plan:
- Reset held 3 Clk mid-flight -> all outputs 0 on the cycle after the first sampled Reset_n=0; kills=0.
- Tank (100,200), facing=2, fire pulse -> next cycle X_Bullet=112, Y_Bullet=212, saveX=100, saveY=200, bullet_dir=2, bullet_active=1; after 3 frame_ticks with hit=01 -> X_Bullet=127.
- In flight, facing=1, Y_Bullet=3; frame_tick -> retired without underflow (Y_Bullet stays 3, bullet_dir=0); fire pressed 10 frames later -> no launch; pressed after 15 frames -> launch.
- hit=00 and opp_alive=0 together on a frame_tick -> kill_pulse high exactly 1 Clk, kills 0→1; repeat for 16 kills -> kills stays 15.
- fire held high continuously for 200 frames, hit=01, large open field -> exactly one bullet that retires at MAX_FRAMES (life 120 frames); no relaunch until fire is released and pressed again.
- hit=00 held between frame_ticks then released before the tick -> bullet not retired; it moves STEP_B on the tick.

Source files
------------

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: per-tank bullet engine. Spawns a bullet on a fire press, steps it once per
// video frame, retires it on opponent hit, wall hit, screen edge or lifetime, and counts kills.
module bullet_ctrl #(
  parameter int STEP_B          = 5,
  parameter int BULLET_SIZE     = 8,
  parameter int TANK_SIZE       = 32,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int MAX_FRAMES      = 120,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] X_Tank,
  input  logic [9:0] Y_Tank,
  input  logic [2:0] facing,
  input  logic [1:0] hit,
  input  logic       opp_alive,
  output logic [9:0] X_Bullet,
  output logic [9:0] Y_Bullet,
  output logic [9:0] saveX,
  output logic [9:0] saveY,
  output logic [2:0] bullet_dir,
  output logic       bullet_active,
  output logic       kill_pulse,
  output logic [3:0] kills
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLIGHT   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  localparam int LIFE_W = $clog2(MAX_FRAMES);
  localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [9:0]        SPAWN_OFS = 10'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [9:0]        STEP      = 10'(STEP_B);
  localparam logic [10:0]       REACH     = 11'(BULLET_SIZE + STEP_B);
  localparam logic [10:0]       RIGHT_LIM = 11'(SCREEN_W - 1);
  localparam logic [10:0]       DOWN_LIM  = 11'(SCREEN_H - 1);
  localparam logic [LIFE_W-1:0] LIFE_LAST = LIFE_W'(MAX_FRAMES - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_FRAMES - 1);

  logic [1:0]        state_q, state_d;
  logic              frame_s1_q, frame_s1_d, frame_s2_q, frame_s2_d, frame_s3_q, frame_s3_d;
  logic              fire_s_q, fire_s_d, fire_prev_q, fire_prev_d;
  logic [9:0]        x_q, x_d, y_q, y_d, sx_q, sx_d, sy_q, sy_d;
  logic [2:0]        dir_q, dir_d;
  logic              act_q, act_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              kill_pulse_q, kill_pulse_d;
  logic [3:0]        kills_q, kills_d;

  logic        frame_tick, fire_edge, facing_ok, leaving, retire;
  logic [10:0] right_sum, down_sum;

  always_comb begin
    frame_s1_d  = frame_clk;
    frame_s2_d  = frame_s1_q;
    frame_s3_d  = frame_s2_q;
    fire_s_d    = fire;
    fire_prev_d = fire_s_q;

    frame_tick = frame_s2_q & ~frame_s3_q;
    fire_edge  = fire_s_q & ~fire_prev_q;
    facing_ok  = (facing >= DIR_UP) && (facing <= DIR_DOWN);

    // Edge tests are done at 11 bits so a bullet near 1023 can never wrap to a small value.
    right_sum = {1'b0, x_q} + REACH;
    down_sum  = {1'b0, y_q} + REACH;
    case (dir_q)
      DIR_UP:    leaving = (y_q < STEP);
      DIR_LEFT:  leaving = (x_q < STEP);
      DIR_RIGHT: leaving = (right_sum > RIGHT_LIM);
      DIR_DOWN:  leaving = (down_sum > DOWN_LIM);
      default:   leaving = 1'b1;
    endcase

    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    dir_d        = dir_q;
    act_d        = act_q;
    life_d       = life_q;
    cool_d       = cool_q;
    kills_d      = kills_q;
    kill_pulse_d = 1'b0;
    retire       = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire_edge && facing_ok) begin
          x_d     = X_Tank + SPAWN_OFS;
          y_d     = Y_Tank + SPAWN_OFS;
          sx_d    = X_Tank;
          sy_d    = Y_Tank;
          dir_d   = facing;
          act_d   = 1'b1;
          life_d  = '0;
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        if (frame_tick) begin
          if (!opp_alive) begin
            retire       = 1'b1;
            kill_pulse_d = 1'b1;
            if (kills_q != 4'hF) kills_d = kills_q + 4'd1;
          end else if (hit == 2'b00) begin
            retire = 1'b1;
          end else if (leaving) begin
            retire = 1'b1;
          end else if (life_q == LIFE_LAST) begin
            retire = 1'b1;
          end else begin
            case (dir_q)
              DIR_UP:    y_d = y_q - STEP;
              DIR_DOWN:  y_d = y_q + STEP;
              DIR_LEFT:  x_d = x_q - STEP;
              DIR_RIGHT: x_d = x_q + STEP;
              default:   x_d = x_q;
            endcase
            life_d = life_q + LIFE_W'(1);
          end
          if (retire) begin
            act_d   = 1'b0;
            dir_d   = '0;
            cool_d  = '0;
            state_d = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cool_q == COOL_LAST) state_d = IDLE;
          else                     cool_d  = cool_q + COOL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      frame_s1_q   <= 1'b0;
      frame_s2_q   <= 1'b0;
      frame_s3_q   <= 1'b0;
      fire_s_q     <= 1'b0;
      fire_prev_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      dir_q        <= '0;
      act_q        <= 1'b0;
      life_q       <= '0;
      cool_q       <= '0;
      kill_pulse_q <= 1'b0;
      kills_q      <= '0;
    end else begin
      state_q      <= state_d;
      frame_s1_q   <= frame_s1_d;
      frame_s2_q   <= frame_s2_d;
      frame_s3_q   <= frame_s3_d;
      fire_s_q     <= fire_s_d;
      fire_prev_q  <= fire_prev_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      dir_q        <= dir_d;
      act_q        <= act_d;
      life_q       <= life_d;
      cool_q       <= cool_d;
      kill_pulse_q <= kill_pulse_d;
      kills_q      <= kills_d;
    end
  end

  assign X_Bullet      = x_q;
  assign Y_Bullet      = y_q;
  assign saveX         = sx_q;
  assign saveY         = sy_q;
  assign bullet_dir    = dir_q;
  assign bullet_active = act_q;
  assign kill_pulse    = kill_pulse_q;
  assign kills         = kills_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scoreboard bench for bullet_ctrl: a reference model pushes expected output snapshots
// {X,Y,saveX,saveY,dir,active,kills} as stimulus is driven; each is popped and compared after the DUT responds.
module tb_bullet_ctrl;

  logic       Clk, Reset_n, frame_clk, fire, opp_alive;
  logic [9:0] X_Tank, Y_Tank;
  logic [2:0] facing;
  logic [1:0] hit;
  logic [9:0] X_Bullet, Y_Bullet, saveX, saveY;
  logic [2:0] bullet_dir;
  logic       bullet_active, kill_pulse;
  logic [3:0] kills;

  bullet_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
    .X_Tank(X_Tank), .Y_Tank(Y_Tank), .facing(facing), .hit(hit), .opp_alive(opp_alive),
    .X_Bullet(X_Bullet), .Y_Bullet(Y_Bullet), .saveX(saveX), .saveY(saveY),
    .bullet_dir(bullet_dir), .bullet_active(bullet_active), .kill_pulse(kill_pulse), .kills(kills)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [47:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   kp_cnt;

  logic [9:0] mx, my, msx, msy;
  logic [2:0] mdir;
  logic       mact;
  logic [3:0] mk;

  function automatic logic [47:0] snap();
    return {X_Bullet, Y_Bullet, saveX, saveY, bullet_dir, bullet_active, kills};
  endfunction

  function automatic logic [47:0] exp_vec();
    return {mx, my, msx, msy, mdir, mact, mk};
  endfunction

  task automatic push_exp(input string n);
    exp_t t;
    t.name = n;
    t.v    = exp_vec();
    sb.push_back(t);
  endtask

  task automatic m_launch();
    mx = X_Tank + 10'd12; my = Y_Tank + 10'd12;
    msx = X_Tank; msy = Y_Tank; mdir = facing; mact = 1'b1;
  endtask

  task automatic m_retire();
    mdir = 3'd0; mact = 1'b0;
  endtask

  task automatic frame();
    kp_cnt = 0;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) begin @(negedge Clk); kp_cnt += int'(kill_pulse); end
    frame_clk = 1'b0;
    repeat (3) begin @(negedge Clk); kp_cnt += int'(kill_pulse); end
  endtask

  task automatic press_fire(input bit hold);
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    if (!hold) fire = 1'b0;
  endtask

  task automatic cool_down();
    repeat (15) frame();
  endtask

  task automatic test_reset();
    mx = 0; my = 0; msx = 0; msy = 0; mdir = 0; mact = 0; mk = 0;
    push_exp("reset_state");
    @(negedge Clk);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    vectors++;
    if (kill_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_kill_pulse: got %b expected 0", kill_pulse); end
    Reset_n = 1'b1;
  endtask

  task automatic test_launch_move();
    X_Tank = 10'd100; Y_Tank = 10'd200; facing = 3'd2; hit = 2'b01; opp_alive = 1'b1;
    m_launch(); push_exp("launch_right");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    for (int i = 0; i < 3; i++) begin
      mx = mx + 10'd5; push_exp("move_right");
      frame();
      e = sb.pop_front(); vectors++;
      if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    end
    hit = 2'b00; m_retire(); push_exp("wall_retire");
    frame();
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    vectors++;
    if (kp_cnt != 0) begin miscompares++; $display("FAIL wall_no_kill: got %0d pulses expected 0", kp_cnt); end
    hit = 2'b01;
    cool_down();
  endtask

  task automatic test_up_edge_cooldown();
    X_Tank = 10'd300; Y_Tank = 10'd1; facing = 3'd1;
    m_launch(); push_exp("launch_up");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    for (int i = 0; i < 2; i++) begin
      my = my - 10'd5; push_exp("move_up");
      frame();
      e = sb.pop_front(); vectors++;
      if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    end
    m_retire(); push_exp("up_edge_retire_y3");
    frame();
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    repeat (10) frame();
    push_exp("cooldown_10_fire_dropped");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    repeat (4) frame();
    push_exp("cooldown_14_fire_dropped");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    frame();
    m_launch(); push_exp("cooldown_15_fire_accepted");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    hit = 2'b00; m_retire(); frame(); hit = 2'b01;
    cool_down();
  endtask

  task automatic test_invalid_facing_and_down_edge();
    X_Tank = 10'd300; Y_Tank = 10'd420;
    facing = 3'd0; push_exp("facing0_ignored");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    facing = 3'd5; push_exp("facing5_ignored");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    facing = 3'd4;
    m_launch(); push_exp("launch_down");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    while (int'(my) + 8 + 5 <= 479) begin
      my = my + 10'd5; push_exp("move_down");
      frame();
      e = sb.pop_front(); vectors++;
      if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    end
    m_retire(); push_exp("down_edge_retire");
    frame();
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    cool_down();
  endtask

  task automatic test_hit_between_frames();
    X_Tank = 10'd200; Y_Tank = 10'd200; facing = 3'd3;
    m_launch(); press_fire(0);
    @(negedge Clk) begin hit = 2'b00; opp_alive = 1'b0; end
    repeat (3) @(negedge Clk);
    hit = 2'b01; opp_alive = 1'b1;
    mx = mx - 10'd5; push_exp("glitch_ignored_moved_left");
    frame();
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    vectors++;
    if (kp_cnt != 0) begin miscompares++; $display("FAIL glitch_no_kill: got %0d pulses expected 0", kp_cnt); end
    hit = 2'b00; m_retire(); frame(); hit = 2'b01;
    cool_down();
  endtask

  task automatic test_back_to_back_held_fire();
    X_Tank = 10'd0; Y_Tank = 10'd100; facing = 3'd2;
    m_launch(); push_exp("held_launch");
    press_fire(1);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    repeat (119) begin frame(); mx = mx + 10'd5; end
    push_exp("life_119_still_active");
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    m_retire(); push_exp("life_120_retire");
    frame();
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    repeat (80) frame();
    push_exp("held_fire_no_relaunch");
    @(negedge Clk);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    fire = 1'b0;
    repeat (3) @(negedge Clk);
    m_launch(); push_exp("relaunch_after_release");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    hit = 2'b00; m_retire(); frame(); hit = 2'b01;
    cool_down();
  endtask

  task automatic test_kills();
    for (int k = 1; k <= 16; k++) begin
      X_Tank = 10'd100; Y_Tank = 10'd100; facing = 3'd1;
      m_launch(); press_fire(0);
      hit = 2'b00; opp_alive = 1'b0;
      m_retire(); mk = (k > 15) ? 4'd15 : 4'(k);
      push_exp("kill_count");
      frame();
      e = sb.pop_front(); vectors++;
      if (snap() !== e.v) begin miscompares++; $display("FAIL %s k=%0d: got %h expected %h", e.name, k, snap(), e.v); end
      vectors++;
      if (kp_cnt != 1) begin miscompares++; $display("FAIL kill_pulse_width k=%0d: got %0d cycles expected 1", k, kp_cnt); end
      hit = 2'b01; opp_alive = 1'b1;
      cool_down();
    end
  endtask

  task automatic test_reset_midflight();
    X_Tank = 10'd50; Y_Tank = 10'd60; facing = 3'd4;
    m_launch(); press_fire(0);
    frame();
    @(negedge Clk) Reset_n = 1'b0;
    mx = 0; my = 0; msx = 0; msy = 0; mdir = 0; mact = 0; mk = 0;
    push_exp("reset_midflight");
    @(negedge Clk);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    m_launch(); push_exp("launch_after_reset");
    press_fire(0);
    e = sb.pop_front(); vectors++;
    if (snap() !== e.v) begin miscompares++; $display("FAIL %s: got %h expected %h", e.name, snap(), e.v); end
  endtask

  initial begin
    Reset_n = 1'b0; fire = 1'b0; frame_clk = 1'b0;
    X_Tank = '0; Y_Tank = '0; facing = '0; hit = 2'b01; opp_alive = 1'b1;
    repeat (3) @(posedge Clk);
    test_reset();
    test_launch_move();
    test_up_edge_cooldown();
    test_invalid_facing_and_down_edge();
    test_hit_between_frames();
    test_back_to_back_held_fire();
    test_kills();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
